// File: rtl/mobilenet_if.sv
// mobilenet_if: 32-bit AXI4 memory-mapped bundle with master/slave views.
interface mobilenet_if;
  logic        awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;
  logic        rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/mobilenet.sv
// mobilenet: 4-byte signed dot product of image words with one weight word over AXI bursts; MOBILENET_RELU_EN clamps negatives.
module mobilenet #(
  parameter logic [31:0] IMG_ADDR   = 32'h0000_0000,
  parameter logic [31:0] WGT_ADDR   = 32'h0001_0000,
  parameter logic [31:0] OUT_ADDR   = 32'h0002_0000,
  parameter int          NUM_BURSTS = 4
) (
  input  logic       clk,
  input  logic       rstn,
  mobilenet_if.master m_axi_img,
  mobilenet_if.master m_axi_input,
  mobilenet_if.master m_axi_output
);
  typedef enum logic [3:0] {IDLE, WGT_AR, WGT_R, IMG_AR, IMG_R, OUT_AW, OUT_W, OUT_B, DONE} state_t;
  state_t      state;
  logic [31:0] wgt;
  logic [31:0] res_buf [16];
  logic [3:0]  beat;
  logic [15:0] burst;
  logic        img_arvalid, img_rready, in_arvalid, in_rready;
  logic        out_awvalid, out_wvalid, out_bready;
  logic [31:0] dot, res;
  logic [31:0] burst_off;
  logic        unused;
  function automatic logic [31:0] sx(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction
  always_comb begin
    dot = '0;
    for (int k = 0; k < 4; k++) dot = dot + sx(m_axi_img.rdata[8*k+:8]) * sx(wgt[8*k+:8]);
`ifdef MOBILENET_RELU_EN
    res = dot[31] ? '0 : dot;
`else
    res = dot;
`endif
  end
  assign burst_off = {10'b0, burst, 6'b0};
  // image read channel
  assign m_axi_img.arid    = 1'b0;
  assign m_axi_img.araddr  = IMG_ADDR + burst_off;
  assign m_axi_img.arlen   = 8'd15;
  assign m_axi_img.arsize  = 3'b010;
  assign m_axi_img.arburst = 2'b01;
  assign m_axi_img.arlock  = 1'b0;
  assign m_axi_img.arcache = 4'd0;
  assign m_axi_img.arprot  = 3'd0;
  assign m_axi_img.arqos   = 4'd0;
  assign m_axi_img.arvalid = img_arvalid;
  assign m_axi_img.rready  = img_rready;
  assign m_axi_img.awid    = 1'b0;
  assign m_axi_img.awaddr  = '0;
  assign m_axi_img.awlen   = '0;
  assign m_axi_img.awsize  = 3'b010;
  assign m_axi_img.awburst = 2'b01;
  assign m_axi_img.awlock  = 1'b0;
  assign m_axi_img.awcache = 4'd0;
  assign m_axi_img.awprot  = 3'd0;
  assign m_axi_img.awqos   = 4'd0;
  assign m_axi_img.awvalid = 1'b0;
  assign m_axi_img.wdata   = '0;
  assign m_axi_img.wstrb   = '0;
  assign m_axi_img.wlast   = 1'b0;
  assign m_axi_img.wvalid  = 1'b0;
  assign m_axi_img.bready  = 1'b1;
  // weight read channel
  assign m_axi_input.arid    = 1'b0;
  assign m_axi_input.araddr  = WGT_ADDR;
  assign m_axi_input.arlen   = 8'd0;
  assign m_axi_input.arsize  = 3'b010;
  assign m_axi_input.arburst = 2'b01;
  assign m_axi_input.arlock  = 1'b0;
  assign m_axi_input.arcache = 4'd0;
  assign m_axi_input.arprot  = 3'd0;
  assign m_axi_input.arqos   = 4'd0;
  assign m_axi_input.arvalid = in_arvalid;
  assign m_axi_input.rready  = in_rready;
  assign m_axi_input.awid    = 1'b0;
  assign m_axi_input.awaddr  = '0;
  assign m_axi_input.awlen   = '0;
  assign m_axi_input.awsize  = 3'b010;
  assign m_axi_input.awburst = 2'b01;
  assign m_axi_input.awlock  = 1'b0;
  assign m_axi_input.awcache = 4'd0;
  assign m_axi_input.awprot  = 3'd0;
  assign m_axi_input.awqos   = 4'd0;
  assign m_axi_input.awvalid = 1'b0;
  assign m_axi_input.wdata   = '0;
  assign m_axi_input.wstrb   = '0;
  assign m_axi_input.wlast   = 1'b0;
  assign m_axi_input.wvalid  = 1'b0;
  assign m_axi_input.bready  = 1'b1;
  // result write channel
  assign m_axi_output.awid    = 1'b0;
  assign m_axi_output.awaddr  = OUT_ADDR + burst_off;
  assign m_axi_output.awlen   = 8'd15;
  assign m_axi_output.awsize  = 3'b010;
  assign m_axi_output.awburst = 2'b01;
  assign m_axi_output.awlock  = 1'b0;
  assign m_axi_output.awcache = 4'd0;
  assign m_axi_output.awprot  = 3'd0;
  assign m_axi_output.awqos   = 4'd0;
  assign m_axi_output.awvalid = out_awvalid;
  assign m_axi_output.wdata   = res_buf[beat];
  assign m_axi_output.wstrb   = 4'hF;
  assign m_axi_output.wlast   = beat == 4'd15;
  assign m_axi_output.wvalid  = out_wvalid;
  assign m_axi_output.bready  = out_bready;
  assign m_axi_output.arid    = 1'b0;
  assign m_axi_output.araddr  = '0;
  assign m_axi_output.arlen   = '0;
  assign m_axi_output.arsize  = 3'b010;
  assign m_axi_output.arburst = 2'b01;
  assign m_axi_output.arlock  = 1'b0;
  assign m_axi_output.arcache = 4'd0;
  assign m_axi_output.arprot  = 3'd0;
  assign m_axi_output.arqos   = 4'd0;
  assign m_axi_output.arvalid = 1'b0;
  assign m_axi_output.rready  = 1'b1;
  assign unused = ^{m_axi_img.awready, m_axi_img.wready, m_axi_img.bid, m_axi_img.bresp, m_axi_img.bvalid,
                    m_axi_img.rid, m_axi_img.rresp, m_axi_img.rlast,
                    m_axi_input.awready, m_axi_input.wready, m_axi_input.bid, m_axi_input.bresp,
                    m_axi_input.bvalid, m_axi_input.rid, m_axi_input.rresp, m_axi_input.rlast,
                    m_axi_output.bid, m_axi_output.bresp, m_axi_output.arready, m_axi_output.rid,
                    m_axi_output.rdata, m_axi_output.rresp, m_axi_output.rlast, m_axi_output.rvalid};
  // beat counts image beats in IMG_R and wraps to 0 so OUT_W starts at result[0]
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wgt         <= '0;
      beat        <= '0;
      burst       <= '0;
      img_arvalid <= 1'b0;
      img_rready  <= 1'b0;
      in_arvalid  <= 1'b0;
      in_rready   <= 1'b0;
      out_awvalid <= 1'b0;
      out_wvalid  <= 1'b0;
      out_bready  <= 1'b0;
      for (int i = 0; i < 16; i++) res_buf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_arvalid <= 1'b1;
          state      <= WGT_AR;
        end
        WGT_AR: if (m_axi_input.arready) begin
          in_arvalid <= 1'b0;
          in_rready  <= 1'b1;
          state      <= WGT_R;
        end
        WGT_R: if (m_axi_input.rvalid) begin
          wgt         <= m_axi_input.rdata;
          in_rready   <= 1'b0;
          img_arvalid <= 1'b1;
          state       <= IMG_AR;
        end
        IMG_AR: if (m_axi_img.arready) begin
          img_arvalid <= 1'b0;
          img_rready  <= 1'b1;
          beat        <= '0;
          state       <= IMG_R;
        end
        IMG_R: if (m_axi_img.rvalid) begin
          res_buf[beat] <= res;
          beat          <= beat + 4'd1;
          if (beat == 4'd15) begin
            img_rready  <= 1'b0;
            out_awvalid <= 1'b1;
            state       <= OUT_AW;
          end
        end
        OUT_AW: if (m_axi_output.awready) begin
          out_awvalid <= 1'b0;
          out_wvalid  <= 1'b1;
          state       <= OUT_W;
        end
        OUT_W: if (m_axi_output.wready) begin
          beat <= beat + 4'd1;
          if (beat == 4'd15) begin
            out_wvalid <= 1'b0;
            out_bready <= 1'b1;
            state      <= OUT_B;
          end
        end
        OUT_B: if (m_axi_output.bvalid) begin
          out_bready <= 1'b0;
          if (burst == 16'(NUM_BURSTS - 1)) state <= DONE;
          else begin
            burst       <= burst + 16'd1;
            img_arvalid <= 1'b1;
            state       <= IMG_AR;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mobilenet.sv
// tb_mobilenet: randomized AXI slaves plus a dot-product reference model for mobilenet.
module tb_mobilenet;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  mobilenet_if img_if ();
  mobilenet_if in_if ();
  mobilenet_if out_if ();
  mobilenet dut (.clk(clk), .rstn(rstn), .m_axi_img(img_if), .m_axi_input(in_if), .m_axi_output(out_if));
  int errors = 0;
  int checks = 0;
  bit          const_mode;
  logic [31:0] const_img, wgt_word;
  logic [31:0] img_mem [64];
  int          stall;
  logic [31:0] img_ar_q[$], img_len_q[$], in_ar_q[$], in_len_q[$], aw_q[$], awlen_q[$], w_q[$];
  logic [31:0] img_pend[$];
  int in_pend, b_pend, b_cnt, img_beat, wlast_bad, early_w, unstable;
  bit img_r_hs, in_r_hs, b_hs;
  bit img_ar_st, in_ar_st, aw_st, w_st;
  logic [31:0] p_img_ar, p_aw, p_wdata;
  logic p_wlast;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit rdy();
    return $urandom_range(0, 99) >= stall;
  endfunction
  function automatic logic [31:0] img_word(input logic [31:0] a);
    return const_mode ? const_img : img_mem[a[7:2]];
  endfunction
  // reference: result i is the signed byte-wise dot product of image word i with the weight
  function automatic logic [31:0] model(input int i);
    int s;
    byte a, b;
    logic [31:0] px;
    px = const_mode ? const_img : img_mem[i];
    s = 0;
    for (int k = 0; k < 4; k++) begin
      a = px[8*k+:8];
      b = wgt_word[8*k+:8];
      s += int'(a) * int'(b);
    end
`ifdef MOBILENET_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction
  initial begin
    {img_if.awready, img_if.wready, img_if.bvalid, img_if.bid, img_if.bresp} = '0;
    {in_if.awready, in_if.wready, in_if.bvalid, in_if.bid, in_if.bresp} = '0;
    {out_if.arready, out_if.rvalid, out_if.rdata, out_if.rid, out_if.rresp, out_if.rlast} = '0;
    {img_if.rid, img_if.rresp, img_if.rlast, img_if.rdata, in_if.rid, in_if.rresp, in_if.rlast, in_if.rdata} = '0;
    {out_if.bid, out_if.bresp} = '0;
  end
  // slaves and monitor: retire last handshakes, drive, then note handshakes for the coming edge
  always @(negedge clk) begin
    if (!rstn) begin
      {img_if.arready, img_if.rvalid, in_if.arready, in_if.rvalid} = '0;
      {out_if.awready, out_if.wready, out_if.bvalid} = '0;
      img_ar_q.delete(); img_len_q.delete(); in_ar_q.delete(); in_len_q.delete();
      aw_q.delete(); awlen_q.delete(); w_q.delete(); img_pend.delete();
      {in_pend, b_pend, b_cnt, img_beat, wlast_bad, early_w, unstable} = '0;
      {img_r_hs, in_r_hs, b_hs, img_ar_st, in_ar_st, aw_st, w_st} = '0;
    end else begin
      if (img_r_hs) begin
        img_if.rvalid = 1'b0;
        img_r_hs = 1'b0;
        img_beat++;
        if (img_beat == 16) begin
          img_beat = 0;
          void'(img_pend.pop_front());
        end
      end
      if (in_r_hs) begin
        in_if.rvalid = 1'b0;
        in_r_hs = 1'b0;
        in_pend--;
      end
      if (b_hs) begin
        out_if.bvalid = 1'b0;
        b_hs = 1'b0;
      end
      img_if.arready = rdy();
      in_if.arready  = rdy();
      out_if.awready = rdy();
      out_if.wready  = rdy();
      if (!img_if.rvalid && img_pend.size() > 0 && rdy()) begin
        img_if.rvalid = 1'b1;
        img_if.rdata  = img_word(img_pend[0] + 32'(img_beat * 4));
      end
      if (!in_if.rvalid && in_pend > 0 && rdy()) begin
        in_if.rvalid = 1'b1;
        in_if.rdata  = wgt_word;
      end
      if (!out_if.bvalid && b_pend > 0 && rdy()) out_if.bvalid = 1'b1;
      if (img_ar_st && (!img_if.arvalid || img_if.araddr !== p_img_ar)) unstable++;
      if (in_ar_st && !in_if.arvalid) unstable++;
      if (aw_st && (!out_if.awvalid || out_if.awaddr !== p_aw)) unstable++;
      if (w_st && (!out_if.wvalid || out_if.wdata !== p_wdata || out_if.wlast !== p_wlast)) unstable++;
      if (out_if.wvalid && int'(aw_q.size()) * 16 <= int'(w_q.size())) early_w++;
      if (img_if.arvalid && img_if.arready) begin
        img_ar_q.push_back(img_if.araddr);
        img_len_q.push_back(32'(img_if.arlen));
        img_pend.push_back(img_if.araddr);
      end
      if (in_if.arvalid && in_if.arready) begin
        in_ar_q.push_back(in_if.araddr);
        in_len_q.push_back(32'(in_if.arlen));
        in_pend++;
      end
      if (img_if.rvalid && img_if.rready) img_r_hs = 1'b1;
      if (in_if.rvalid && in_if.rready) in_r_hs = 1'b1;
      if (out_if.awvalid && out_if.awready) begin
        aw_q.push_back(out_if.awaddr);
        awlen_q.push_back(32'(out_if.awlen));
      end
      if (out_if.wvalid && out_if.wready) begin
        if (out_if.wlast !== (w_q.size() % 16 == 15)) wlast_bad++;
        w_q.push_back(out_if.wdata);
        if (w_q.size() % 16 == 0) b_pend++;
      end
      if (out_if.bvalid && out_if.bready) begin
        b_hs = 1'b1;
        b_pend--;
        b_cnt++;
      end
      img_ar_st = img_if.arvalid && !img_if.arready;
      in_ar_st  = in_if.arvalid && !in_if.arready;
      aw_st     = out_if.awvalid && !out_if.awready;
      w_st      = out_if.wvalid && !out_if.wready;
      p_img_ar  = img_if.araddr;
      p_aw      = out_if.awaddr;
      p_wdata   = out_if.wdata;
      p_wlast   = out_if.wlast;
    end
  end
  task automatic start_run(input bit cm, input logic [31:0] ci, input logic [31:0] cw, input int st);
    rstn = 1'b0;
    const_mode = cm;
    const_img = ci;
    wgt_word = cw;
    stall = st;
    for (int i = 0; i < 64; i++) img_mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valids", {img_if.arvalid, in_if.arvalid, out_if.awvalid, out_if.wvalid}, 0);
    check("rst_readys", {img_if.rready, in_if.rready, out_if.bready}, 0);
    check("tie_off", {img_if.awvalid, img_if.wvalid, img_if.bready, in_if.awvalid, in_if.wvalid,
                      in_if.bready, out_if.arvalid, out_if.rready}, 8'b0010_0101);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_arvalid", in_if.arvalid, 0);
    @(negedge clk);
    check("wgt_arvalid", in_if.arvalid, 1);
  endtask
  task automatic finish_run();
    int n_r, n_w;
    for (int i = 0; i < 8000 && b_cnt < 4; i++) @(negedge clk);
    check("done_bursts", b_cnt, 4);
    n_r = img_ar_q.size() + in_ar_q.size() + aw_q.size();
    n_w = w_q.size();
    repeat (30) @(negedge clk);
    check("quiet_addr", img_ar_q.size() + in_ar_q.size() + aw_q.size(), n_r);
    check("quiet_data", w_q.size(), n_w);
    check("quiet_valid", {img_if.arvalid, in_if.arvalid, out_if.awvalid, out_if.wvalid}, 0);
    check("w_count", w_q.size(), 64);
    for (int i = 0; i < 64; i++) if (i < w_q.size()) check($sformatf("wdata[%0d]", i), w_q[i], model(i));
    check("aw_count", aw_q.size(), 4);
    check("img_ar_count", img_ar_q.size(), 4);
    for (int b = 0; b < 4; b++) begin
      if (b < aw_q.size()) begin
        check($sformatf("awaddr[%0d]", b), aw_q[b], 32'h0002_0000 + 32'(64 * b));
        check($sformatf("awlen[%0d]", b), awlen_q[b], 15);
      end
      if (b < img_ar_q.size()) begin
        check($sformatf("img_araddr[%0d]", b), img_ar_q[b], 32'(64 * b));
        check($sformatf("img_arlen[%0d]", b), img_len_q[b], 15);
      end
    end
    check("in_ar_count", in_ar_q.size(), 1);
    if (in_ar_q.size() > 0) begin
      check("in_araddr", in_ar_q[0], 32'h0001_0000);
      check("in_arlen", in_len_q[0], 0);
    end
    check("wlast_pos", wlast_bad, 0);
    check("w_before_aw", early_w, 0);
    check("valid_stable", unstable, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    start_run(1'b1, 32'd1234, 32'd1234, 0);
    finish_run();
    if (w_q.size() > 0) check("wdata_1234", w_q[0], 32'h0000_0854);
    start_run(1'b1, 32'h0000_00FF, 32'h0000_0001, 0);
    finish_run();
`ifdef MOBILENET_RELU_EN
    if (w_q.size() > 0) check("relu_neg", w_q[0], 32'h0000_0000);
`else
    if (w_q.size() > 0) check("raw_neg", w_q[0], 32'hFFFF_FFFF);
`endif
    start_run(1'b0, 32'd0, $urandom, 50);
    finish_run();
    start_run(1'b0, 32'd0, $urandom, 40);
    for (int i = 0; i < 8000 && w_q.size() < 35; i++) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_wvalid", out_if.wvalid, 1);
    check("pre_rst_burst", aw_q.size(), 3);
    rstn = 1'b0;
    #1;
    check("mid_rst_valids", {img_if.arvalid, in_if.arvalid, out_if.awvalid, out_if.wvalid}, 0);
    check("mid_rst_readys", {img_if.rready, in_if.rready, out_if.bready}, 0);
    start_run(1'b0, 32'd0, $urandom, 40);
    finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mobilenet.md
MOBILENET -- requirements
Module: mobilenet

Interface
REQ-001 SHALL have parameter IMG_ADDR, 32'h0000_0000, byte base address of image pixel words.
REQ-002 SHALL have parameter WGT_ADDR, 32'h0001_0000, byte address of the single weight word.
REQ-003 SHALL have parameter OUT_ADDR, 32'h0002_0000, byte base address of the result words.
REQ-004 SHALL have parameter NUM_BURSTS, 4, number of 16-beat image bursts processed (range 1..65535).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port m_axi_img, axi_mm master, DATA 32 / ADDR 32, image read channel.
REQ-008 SHALL have port m_axi_input, axi_mm master, DATA 32 / ADDR 32, weight read channel.
REQ-009 SHALL have port m_axi_output, axi_mm master, DATA 32 / ADDR 32, result write channel.

Function
REQ-010 SHALL use the FSM IDLE -> WGT_AR -> WGT_R -> IMG_AR -> IMG_R -> OUT_AW -> OUT_W -> OUT_B -> (IMG_AR if bursts remain, else DONE).
- IDLE: exactly one cycle after reset release.
- DONE: absorbing until reset.
REQ-011 SHALL issue in WGT_AR one read on m_axi_input: araddr=WGT_ADDR, arlen=0, arvalid held until arready.
REQ-012 SHALL capture rdata in WGT_R on the first rvalid&&rready beat, with rready=1 only in WGT_R.
REQ-013 SHALL issue in IMG_AR on m_axi_img: araddr=IMG_ADDR+64*burst_index, arlen=15.
REQ-014 SHALL accept exactly 16 beats in IMG_R, counted internally; rlast, rresp and rid are ignored, so a slave that never asserts rlast does not hang the block.
REQ-015 SHALL, per image beat i, store result[i] = sum over k=0..3 of signed(img byte k) * signed(wgt byte k), sign-extended to 32 bits, into a 16-entry buffer.
REQ-016 SHALL issue in OUT_AW: awaddr=OUT_ADDR+64*burst_index, awlen=15.
REQ-017 SHALL raise wvalid only after the AW handshake completes.
REQ-018 SHALL in OUT_W drive wdata=result[beat] and wstrb=4'hF, with wlast=1 on beat 15 only, advancing on wvalid&&wready.
REQ-019 SHALL in OUT_B hold bready=1 until bvalid; bresp and bid are ignored.
REQ-020 SHALL drive on all active channels: id=0, size=3'b010, burst=INCR (2'b01), cache=0, prot=0, lock=0, qos=0.
REQ-021 SHALL tie off unused channels: write channels of m_axi_img and m_axi_input have awvalid=wvalid=0 and bready=1; read channel of m_axi_output has arvalid=0 and rready=1.
REQ-022 SHALL hold each valid stable with its payload constant until its ready; each channel has at most one outstanding transaction.
REQ-023 SHALL accept handshakes whose ready was already high before valid rose (always-ready slave).

Reset
REQ-024 SHALL asynchronously, on rstn low, force:
- all arvalid/awvalid/wvalid/rready to 0
- state to IDLE
- counters, buffer and weight register to 0
REQ-025 SHALL, on reset asserted mid-transfer, drop valids the same instant; after release it restarts from IDLE with burst_index=0.

Configuration
REQ-026 SHALL, with macro MOBILENET_RELU_EN defined, clamp negative results to 0 before buffering; without it, results are stored as raw signed 32-bit values.

Verification
REQ-027 SHALL verify: always-ready slave, all rdata=32'd1234, rlast stuck 0 -> 64 output beats, each wdata=32'h0000_0854 (bytes D2,04: 2116+16), no hang.
REQ-028 SHALL verify: same run -> awaddr sequence 0x20000, 0x20040, 0x20080, 0x200C0; img araddr 0x0, 0x40, 0x80, 0xC0; exactly one input read at 0x10000 with arlen 0; then DONE with no further traffic.
REQ-029 SHALL verify: img rdata=32'h0000_00FF, wgt=32'h0000_0001 -> wdata=32'h0000_0000 with MOBILENET_RELU_EN, 32'hFFFF_FFFF without.
REQ-030 SHALL verify: randomized ready/valid stalls on all channels -> identical data and address sequences; wvalid never precedes the AW handshake; wlast only on every 16th beat.
REQ-031 SHALL verify: rstn pulsed low during OUT_W of burst 2 -> valids drop immediately; after release, a fresh weight read occurs and the sequence restarts at awaddr 0x20000.
